// File: rtl/hls_accel_ctrl_pkg.sv
// Shared constants, FSM state type and helpers for the HLS accelerator control block.
package hls_accel_ctrl_pkg;

    localparam logic [4:0] CSR_CTRL   = 5'h00;
    localparam logic [4:0] CSR_STATUS = 5'h04;
    localparam logic [4:0] CSR_LEN    = 5'h08;
    localparam logic [4:0] CSR_RET    = 5'h0C;
    localparam logic [4:0] CSR_CYCLES = 5'h10;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    localparam int ST_BUSY     = 0;
    localparam int ST_DONE     = 1;
    localparam int ST_TIMEOUT  = 2;
    localparam int ST_CONFLICT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ABORT = 2'd2
    } state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hls_accel_ctrl_if.sv
// UDM-side bus bundle: CSR window plus host access to the shared test RAM.
interface hls_accel_ctrl_if #(parameter int ADDR_W = 10);

    logic              csr_req_i;
    logic              csr_we_i;
    logic [4:0]        csr_addr_bi;
    logic [31:0]       csr_wdata_bi;
    logic              csr_resp_o;
    logic [31:0]       csr_rdata_bo;
    logic              host_req_i;
    logic              host_we_i;
    logic [ADDR_W-1:0] host_addr_bi;
    logic [31:0]       host_wdata_bi;
    logic              host_resp_o;
    logic [31:0]       host_rdata_bo;

    modport master (
        output csr_req_i, csr_we_i, csr_addr_bi, csr_wdata_bi,
        output host_req_i, host_we_i, host_addr_bi, host_wdata_bi,
        input  csr_resp_o, csr_rdata_bo, host_resp_o, host_rdata_bo
    );

    modport slave (
        input  csr_req_i, csr_we_i, csr_addr_bi, csr_wdata_bi,
        input  host_req_i, host_we_i, host_addr_bi, host_wdata_bi,
        output csr_resp_o, csr_rdata_bo, host_resp_o, host_rdata_bo
    );

endinterface

// File: rtl/hls_mem_arb.sv
// Shared RAM port mux: host owns the port while idle, the accelerator while busy.
module hls_mem_arb
    import hls_accel_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              busy,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_wdata,
    output logic              host_resp,
    output logic [31:0]       host_rdata,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic              acc_we,
    input  logic [31:0]       acc_wdata,
    output logic [31:0]       acc_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              conflict
);

    logic [ADDR_W-1:0] sel_addr_s;
    logic              sel_we_s;
    logic [31:0]       sel_wdata_s;
    logic [ADDR_W-1:0] ram_addr_r;
    logic              ram_we_r;
    logic [31:0]       ram_wdata_r;
    logic              rd_pend_r;
    logic              rd_blk_r;
    logic              resp_r;
    logic              resp_blk_r;

    // Ownership select; an idle accelerator can never write because the host path is chosen.
    always_comb begin
        sel_addr_s  = host_addr;
        sel_we_s    = host_req && host_we;
        sel_wdata_s = host_wdata;
        if (busy) begin
            sel_addr_s  = acc_addr;
            sel_we_s    = acc_we;
            sel_wdata_s = acc_wdata;
        end else begin
            sel_addr_s  = host_addr;
            sel_we_s    = host_req && host_we;
            sel_wdata_s = host_wdata;
        end
    end

    // Register the RAM port and carry host reads two stages to line up with RAM data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ram_addr_r  <= '0;
            ram_we_r    <= 1'b0;
            ram_wdata_r <= 32'd0;
            rd_pend_r   <= 1'b0;
            rd_blk_r    <= 1'b0;
            resp_r      <= 1'b0;
            resp_blk_r  <= 1'b0;
        end else begin
            ram_addr_r  <= sel_addr_s;
            ram_we_r    <= sel_we_s;
            ram_wdata_r <= sel_wdata_s;
            rd_pend_r   <= host_req && !host_we;
            rd_blk_r    <= host_req && !host_we && busy;
            resp_r      <= rd_pend_r;
            resp_blk_r  <= rd_blk_r;
        end
    end

    assign ram_addr   = ram_addr_r;
    assign ram_we     = ram_we_r;
    assign ram_wdata  = ram_wdata_r;
    // RAM output is already a register; a blocked host read sees zero.
    assign host_resp  = resp_r;
    assign host_rdata = (resp_r && !resp_blk_r) ? ram_rdata : 32'd0;
    assign acc_rdata  = ram_rdata;
    assign conflict   = host_req && busy;

endmodule

// File: rtl/hls_accel_ctrl.sv
// ap_ctrl_hs run controller with CSR window, cycle counter, timeout and shared-RAM arbitration.
module hls_accel_ctrl
    import hls_accel_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    hls_accel_ctrl_if.slave   bus,
    input  logic [ADDR_W-1:0] acc_addr_bi,
    input  logic              acc_we_i,
    input  logic [31:0]       acc_wdata_bi,
    output logic [31:0]       acc_rdata_bo,
    output logic [ADDR_W-1:0] ram_addr_bo,
    output logic              ram_we_o,
    output logic [31:0]       ram_wdata_bo,
    input  logic [31:0]       ram_rdata_bi,
    output logic              ap_start_o,
    output logic              ap_rst_o,
    input  logic              ap_done_i,
    input  logic              ap_ready_i,
    input  logic              ap_idle_i,
    input  logic [31:0]       ap_return_bi,
    output logic [31:0]       len_bo
);

    localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    state_e      state_r, state_s;
    logic        ap_start_r, ap_start_s, ap_rst_r, ap_rst_s;
    logic [31:0] len_r, ret_r, cyc_r, csr_rdata_r, rd_mux_s, status_s;
    logic        done_r, to_r, conf_r, csr_resp_r;
    logic        wr_s, rd_s, start_s, clear_s, expire_s, busy_s, conflict_s;
    logic        unused_s;

    assign unused_s = ap_idle_i;
    assign wr_s     = bus.csr_req_i && bus.csr_we_i;
    assign rd_s     = bus.csr_req_i && !bus.csr_we_i;
    assign start_s  = wr_s && (bus.csr_addr_bi == CSR_CTRL) && bus.csr_wdata_bi[CTRL_START];
    assign clear_s  = wr_s && (bus.csr_addr_bi == CSR_CTRL) && bus.csr_wdata_bi[CTRL_CLEAR];
    assign busy_s   = (state_r != IDLE);
    // Fires in the TIMEOUT-th RUN cycle, so the run lasts exactly TIMEOUT cycles.
    assign expire_s = (TIMEOUT > 0) && (cyc_r == TO_LAST);
    assign status_s = {28'd0, conf_r, to_r, done_r, busy_s};

    // State and handshake output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            ap_start_r <= 1'b0;
            ap_rst_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            ap_start_r <= ap_start_s;
            ap_rst_r   <= ap_rst_s;
        end
    end

    // Next-state logic; done takes priority over a simultaneous timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (start_s) state_s = RUN; else state_s = IDLE;
            RUN:     if (ap_done_i) state_s = IDLE;
                     else if (expire_s) state_s = ABORT;
                     else state_s = RUN;
            ABORT:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output logic: ap_start only rises on run entry, so it cannot reassert within a run.
    always_comb begin
        ap_start_s = 1'b0;
        ap_rst_s   = 1'b0;
        case (state_r)
            IDLE: begin
                ap_start_s = (state_s == RUN);
                ap_rst_s   = 1'b0;
            end
            RUN: begin
                ap_start_s = (state_s == RUN) && ap_start_r && !ap_ready_i;
                ap_rst_s   = (state_s == ABORT);
            end
            default: begin
                ap_start_s = 1'b0;
                ap_rst_s   = 1'b0;
            end
        endcase
    end

    // CSR read decode; misaligned and unmapped offsets read as zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (bus.csr_addr_bi)
            CSR_STATUS: rd_mux_s = status_s;
            CSR_LEN:    rd_mux_s = len_r;
            CSR_RET:    rd_mux_s = ret_r;
            CSR_CYCLES: rd_mux_s = cyc_r;
            default:    rd_mux_s = 32'd0;
        endcase
    end

    // CSRs, sticky status and cycle counter; clear is applied before same-edge sets.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_r       <= 32'd0;
            ret_r       <= 32'd0;
            cyc_r       <= 32'd0;
            done_r      <= 1'b0;
            to_r        <= 1'b0;
            conf_r      <= 1'b0;
            csr_resp_r  <= 1'b0;
            csr_rdata_r <= 32'd0;
        end else begin
            if (wr_s && (bus.csr_addr_bi == CSR_LEN)) len_r <= bus.csr_wdata_bi;
            if ((state_r == IDLE) && start_s) cyc_r <= 32'd0;
            else if (state_r == RUN) cyc_r <= sat_inc(cyc_r);
            if ((state_r == RUN) && ap_done_i) ret_r <= ap_return_bi;
            done_r      <= (done_r && !clear_s) || ((state_r == RUN) && ap_done_i);
            to_r        <= (to_r && !clear_s) || ((state_r == RUN) && !ap_done_i && expire_s);
            conf_r      <= (conf_r && !clear_s) || conflict_s;
            csr_resp_r  <= rd_s;
            csr_rdata_r <= rd_s ? rd_mux_s : 32'd0;
        end
    end

    hls_mem_arb #(.ADDR_W(ADDR_W)) u_arb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .busy       (busy_s),
        .host_req   (bus.host_req_i),
        .host_we    (bus.host_we_i),
        .host_addr  (bus.host_addr_bi),
        .host_wdata (bus.host_wdata_bi),
        .host_resp  (bus.host_resp_o),
        .host_rdata (bus.host_rdata_bo),
        .acc_addr   (acc_addr_bi),
        .acc_we     (acc_we_i),
        .acc_wdata  (acc_wdata_bi),
        .acc_rdata  (acc_rdata_bo),
        .ram_addr   (ram_addr_bo),
        .ram_we     (ram_we_o),
        .ram_wdata  (ram_wdata_bo),
        .ram_rdata  (ram_rdata_bi),
        .conflict   (conflict_s)
    );

    assign bus.csr_resp_o   = csr_resp_r;
    assign bus.csr_rdata_bo = csr_rdata_r;
    assign ap_start_o       = ap_start_r;
    assign ap_rst_o         = ap_rst_r;
    assign len_bo           = len_r;

endmodule
